// File: rtl/runner_ctrl.sv
// Game-loop controller for the runner: frame tick and timer, game state machine,
// saturating speed ramp, obstacle clear-time gate and crash-restart lockout.
module runner_ctrl #(
    parameter int CLK_PER_FRAME  = 555_555,
    parameter int FPS            = 60,
    parameter int TIMER_W        = 6,
    parameter int SPEED_W        = 15,
    parameter int SPEED_INIT     = 6144,
    parameter int MAX_SPEED      = 13312,
    parameter int ACCEL          = 1,
    parameter int CLEAR_FRAMES   = 180,
    parameter int RESTART_FRAMES = 45
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               jump,
    input  logic               pause,
    input  logic               crash,
    output logic               update,
    output logic [TIMER_W-1:0] timer,
    output logic [1:0]         state,
    output logic               started,
    output logic               restart,
    output logic [SPEED_W-1:0] speed,
    output logic               has_obstacles,
    output logic               rng_load
);

    localparam int FRAME_W = $clog2(CLK_PER_FRAME);
    localparam int CLEAR_W = (CLEAR_FRAMES > 0) ? $clog2(CLEAR_FRAMES + 1) : 1;
    localparam int LOCK_W  = (RESTART_FRAMES > 0) ? $clog2(RESTART_FRAMES + 1) : 1;

    typedef enum logic [1:0] {
        WAITING = 2'd0,
        RUNNING = 2'd1,
        CRASHED = 2'd2,
        PAUSED  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [FRAME_W-1:0]  frame_cnt;
    logic                frame_wrap;
    logic [CLEAR_W-1:0]  clear_cnt, clear_d;
    logic [LOCK_W-1:0]   lock_cnt, lock_d;
    logic                lock_full;
    logic                start_run, accel_frame;
    logic [SPEED_W:0]    speed_sum;
    logic [SPEED_W-1:0]  speed_d;
    logic                has_obs_d, started_d, restart_d, rng_load_d;

    assign frame_wrap = (frame_cnt == FRAME_W'(CLK_PER_FRAME - 1));
    assign lock_full  = (lock_cnt == LOCK_W'(RESTART_FRAMES));
    assign state      = state_q;

    // Free-running frame divider; update lands the cycle after the wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
            update    <= 1'b0;
            timer     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            update <= frame_wrap;
            if (frame_wrap) begin
                frame_cnt <= '0;
                timer     <= (timer == TIMER_W'(FPS - 1)) ? '0 : timer + 1'b1;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= WAITING;
        else      state_q <= state_d;
    end

    // Crash out of RUNNING is the only transition not gated by the frame tick.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            WAITING: if (update && jump) state_d = RUNNING;
            RUNNING: begin
                if (crash)                 state_d = CRASHED;
                else if (update && pause)  state_d = PAUSED;
            end
            PAUSED:  if (update && !pause) state_d = RUNNING;
            CRASHED: if (update && jump && lock_full) state_d = RUNNING;
            default: state_d = WAITING;
        endcase
    end

    always_comb begin
        start_run   = (state_d == RUNNING) && ((state_q == WAITING) || (state_q == CRASHED));
        accel_frame = (state_q == RUNNING) && (state_d == RUNNING) && update;
        speed_sum   = {1'b0, speed} + (SPEED_W + 1)'(ACCEL);
        speed_d     = speed;
        clear_d     = clear_cnt;
        lock_d      = lock_cnt;
        has_obs_d   = has_obstacles;
        started_d   = started;
        restart_d   = 1'b0;
        rng_load_d  = rng_load;
        if (start_run) begin
            speed_d    = SPEED_W'(SPEED_INIT);
            clear_d    = '0;
            has_obs_d  = 1'b0;
            started_d  = 1'b1;
            restart_d  = 1'b1;
            rng_load_d = 1'b0;
        end else if (accel_frame) begin
            speed_d = (speed_sum > (SPEED_W + 1)'(MAX_SPEED)) ? SPEED_W'(MAX_SPEED)
                                                              : speed_sum[SPEED_W-1:0];
            if (clear_cnt != CLEAR_W'(CLEAR_FRAMES)) clear_d = clear_cnt + 1'b1;
            if (clear_d == CLEAR_W'(CLEAR_FRAMES))   has_obs_d = 1'b1;
        end else if ((state_q == RUNNING) && crash) begin
            lock_d = '0;
        end else if ((state_q == CRASHED) && update && !lock_full) begin
            lock_d = lock_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            speed         <= '0;
            clear_cnt     <= '0;
            lock_cnt      <= '0;
            has_obstacles <= 1'b0;
            started       <= 1'b0;
            restart       <= 1'b0;
            rng_load      <= 1'b1;
        end else begin
            speed         <= speed_d;
            clear_cnt     <= clear_d;
            lock_cnt      <= lock_d;
            has_obstacles <= has_obs_d;
            started       <= started_d;
            restart       <= restart_d;
            rng_load      <= rng_load_d;
        end
    end

endmodule

// File: tb/tb_runner_ctrl.sv
// Directed bench for runner_ctrl with small frame/limit parameters; expected
// values are hand-derived from the frame timing and speed/lockout rules.
module tb_runner_ctrl;

    localparam int CPF     = 4;
    localparam int FPS     = 6;
    localparam int TIMER_W = 3;
    localparam int SPEED_W = 15;

    logic               clk;
    logic               rst;
    logic               jump;
    logic               pause;
    logic               crash;
    logic               update;
    logic [TIMER_W-1:0] timer;
    logic [1:0]         state;
    logic               started;
    logic               restart;
    logic [SPEED_W-1:0] speed;
    logic               has_obstacles;
    logic               rng_load;

    int checks = 0;
    int errors = 0;

    runner_ctrl #(
        .CLK_PER_FRAME (CPF),
        .FPS           (FPS),
        .TIMER_W       (TIMER_W),
        .SPEED_W       (SPEED_W),
        .SPEED_INIT    (6144),
        .MAX_SPEED     (6150),
        .ACCEL         (4),
        .CLEAR_FRAMES  (3),
        .RESTART_FRAMES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jump         (jump),
        .pause        (pause),
        .crash        (crash),
        .update       (update),
        .timer        (timer),
        .state        (state),
        .started      (started),
        .restart      (restart),
        .speed        (speed),
        .has_obstacles(has_obstacles),
        .rng_load     (rng_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // One clock: returns at the falling edge after the next rising edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic to_tick();
        int n;
        n = 0;
        tick();
        while (update !== 1'b1 && n < 2 * CPF) begin
            tick();
            n++;
        end
        checks++;
        if (update !== 1'b1) begin
            errors++;
            $display("FAIL to_tick: update=%b required 1 within %0d cycles", update, 2 * CPF);
        end
    endtask

    // Advance to the cycle after the next frame tick, where its effects are visible.
    task automatic next_eval();
        to_tick();
        tick();
    endtask

    task automatic do_reset(input logic j);
        rst   = 1'b0;
        jump  = j;
        pause = 1'b0;
        crash = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic       exp_upd;
        logic [TIMER_W-1:0] exp_tmr;
        rst = 1'b0; jump = 1'b0; pause = 1'b0; crash = 1'b0;
        tick();
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL rst_update: got %b required 0", update); end
        checks++; if (timer !== 3'd0) begin errors++; $display("FAIL rst_timer: got %0d required 0", timer); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d required 0", state); end
        checks++; if (started !== 1'b0) begin errors++; $display("FAIL rst_started: got %b required 0", started); end
        checks++; if (restart !== 1'b0) begin errors++; $display("FAIL rst_restart: got %b required 0", restart); end
        checks++; if (speed !== 15'd0) begin errors++; $display("FAIL rst_speed: got %0d required 0", speed); end
        checks++; if (has_obstacles !== 1'b0) begin errors++; $display("FAIL rst_has_obs: got %b required 0", has_obstacles); end
        checks++; if (rng_load !== 1'b1) begin errors++; $display("FAIL rst_rng_load: got %b required 1", rng_load); end
        rst = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp_upd = (k % CPF == 0);
            exp_tmr = TIMER_W'((k / CPF) % FPS);
            checks++; if (update !== exp_upd) begin errors++; $display("FAIL idle_update cycle %0d: got %b required %b", k, update, exp_upd); end
            checks++; if (timer !== exp_tmr) begin errors++; $display("FAIL idle_timer cycle %0d: got %0d required %0d", k, timer, exp_tmr); end
        end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_state: got %0d required 0", state); end
        checks++; if (rng_load !== 1'b1) begin errors++; $display("FAIL idle_rng_load: got %b required 1", rng_load); end
    endtask

    task automatic test_jump_start();
        do_reset(1'b1);
        to_tick();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL start_pre_state: got %0d required 0", state); end
        tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d required 1", state); end
        checks++; if (restart !== 1'b1) begin errors++; $display("FAIL start_restart: got %b required 1", restart); end
        checks++; if (speed !== 15'd6144) begin errors++; $display("FAIL start_speed: got %0d required 6144", speed); end
        checks++; if (started !== 1'b1) begin errors++; $display("FAIL start_started: got %b required 1", started); end
        checks++; if (rng_load !== 1'b0) begin errors++; $display("FAIL start_rng_load: got %b required 0", rng_load); end
        tick();
        checks++; if (restart !== 1'b0) begin errors++; $display("FAIL start_restart_width: got %b required 0", restart); end
        next_eval();
        checks++; if (speed !== 15'd6148) begin errors++; $display("FAIL accel1_speed: got %0d required 6148", speed); end
        checks++; if (has_obstacles !== 1'b0) begin errors++; $display("FAIL accel1_has_obs: got %b required 0", has_obstacles); end
        next_eval();
        checks++; if (speed !== 15'd6150) begin errors++; $display("FAIL accel2_speed: got %0d required 6150", speed); end
        checks++; if (has_obstacles !== 1'b0) begin errors++; $display("FAIL accel2_has_obs: got %b required 0", has_obstacles); end
        next_eval();
        checks++; if (speed !== 15'd6150) begin errors++; $display("FAIL accel3_speed: got %0d required 6150", speed); end
        checks++; if (has_obstacles !== 1'b1) begin errors++; $display("FAIL accel3_has_obs: got %b required 1", has_obstacles); end
        checks++; if (restart !== 1'b0) begin errors++; $display("FAIL accel3_restart: got %b required 0", restart); end
        checks++; if (rng_load !== 1'b0) begin errors++; $display("FAIL accel3_rng_load: got %b required 0", rng_load); end
    endtask

    task automatic test_crash();
        do_reset(1'b1);
        to_tick();
        tick();
        next_eval();
        next_eval();
        next_eval();
        crash = 1'b1;
        tick();
        crash = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL crash_state: got %0d required 2", state); end
        checks++; if (speed !== 15'd6150) begin errors++; $display("FAIL crash_speed: got %0d required 6150", speed); end
        next_eval();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL lock1_state: got %0d required 2", state); end
        checks++; if (speed !== 15'd6150) begin errors++; $display("FAIL lock1_speed: got %0d required 6150", speed); end
        checks++; if (has_obstacles !== 1'b1) begin errors++; $display("FAIL lock1_has_obs: got %b required 1", has_obstacles); end
        next_eval();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL lock2_state: got %0d required 2", state); end
        next_eval();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL relaunch_state: got %0d required 1", state); end
        checks++; if (restart !== 1'b1) begin errors++; $display("FAIL relaunch_restart: got %b required 1", restart); end
        checks++; if (speed !== 15'd6144) begin errors++; $display("FAIL relaunch_speed: got %0d required 6144", speed); end
        checks++; if (has_obstacles !== 1'b0) begin errors++; $display("FAIL relaunch_has_obs: got %b required 0", has_obstacles); end
    endtask

    task automatic test_pause();
        do_reset(1'b1);
        to_tick();
        tick();
        jump = 1'b0;
        next_eval();
        pause = 1'b1;
        next_eval();
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL pause_state: got %0d required 3", state); end
        checks++; if (speed !== 15'd6148) begin errors++; $display("FAIL pause_speed: got %0d required 6148", speed); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                crash = 1'b1;
                tick();
                crash = 1'b0;
                checks++; if (state !== 2'd3) begin errors++; $display("FAIL pause_crash_state: got %0d required 3", state); end
            end
            next_eval();
            checks++; if (state !== 2'd3) begin errors++; $display("FAIL pause_hold_state tick %0d: got %0d required 3", i, state); end
            checks++; if (speed !== 15'd6148) begin errors++; $display("FAIL pause_hold_speed tick %0d: got %0d required 6148", i, speed); end
        end
        pause = 1'b0;
        next_eval();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL resume_state: got %0d required 1", state); end
        checks++; if (speed !== 15'd6148) begin errors++; $display("FAIL resume_speed: got %0d required 6148", speed); end
        next_eval();
        checks++; if (speed !== 15'd6150) begin errors++; $display("FAIL resume_accel: got %0d required 6150", speed); end
    endtask

    task automatic test_crash_pause();
        do_reset(1'b1);
        to_tick();
        tick();
        jump = 1'b0;
        to_tick();
        crash = 1'b1;
        pause = 1'b1;
        tick();
        crash = 1'b0;
        pause = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL crash_pause_state: got %0d required 2", state); end
    endtask

    task automatic test_crash_on_start();
        do_reset(1'b1);
        to_tick();
        crash = 1'b1;
        tick();
        crash = 1'b0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_crash_state: got %0d required 1", state); end
        tick();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_crash_after: got %0d required 1", state); end
    endtask

    task automatic test_reset_mid();
        logic exp_upd;
        do_reset(1'b1);
        to_tick();
        tick();
        next_eval();
        #2 rst = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL mid_rst_state: got %0d required 0", state); end
        checks++; if (speed !== 15'd0) begin errors++; $display("FAIL mid_rst_speed: got %0d required 0", speed); end
        checks++; if (rng_load !== 1'b1) begin errors++; $display("FAIL mid_rst_rng_load: got %b required 1", rng_load); end
        checks++; if (started !== 1'b0) begin errors++; $display("FAIL mid_rst_started: got %b required 0", started); end
        checks++; if (timer !== 3'd0) begin errors++; $display("FAIL mid_rst_timer: got %0d required 0", timer); end
        jump = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= CPF; k++) begin
            tick();
            exp_upd = (k == CPF);
            checks++; if (update !== exp_upd) begin errors++; $display("FAIL mid_rst_update cycle %0d: got %b required %b", k, update, exp_upd); end
        end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL mid_rst_after_state: got %0d required 0", state); end
    endtask

    initial begin
        rst   = 1'b0;
        jump  = 1'b0;
        pause = 1'b0;
        crash = 1'b0;
        test_reset();
        test_jump_start();
        test_crash();
        test_pause();
        test_crash_pause();
        test_crash_on_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/runner_ctrl.md
# runner_ctrl

Parametrised game-loop controller for the runner: generates the per-frame `update` tick and the wrapping frame `timer`, runs the game state machine, and owns game speed and the obstacle clear-time gate. It sits at the runner top level and drives trex, horizon and distance_meter. Over the original inline controller it adds saturating acceleration, a pause mode, a collision-driven CRASHED state and a crash-to-restart path with a lockout.

## Interface

Parameters:
- `CLK_PER_FRAME`, 555_555: clock cycles per frame tick (≥2).
- `FPS`, 60: modulus of `timer`.
- `TIMER_W`, 6: width of `timer`; must satisfy 2^TIMER_W ≥ FPS.
- `SPEED_W`, 15: width of `speed`.
- `SPEED_INIT`, 6144: speed loaded on every (re)start.
- `MAX_SPEED`, 13312: speed ceiling; must be < 2^SPEED_W.
- `ACCEL`, 1: added to `speed` per running frame.
- `CLEAR_FRAMES`, 180: running frames before obstacles are enabled.
- `RESTART_FRAMES`, 45: frames in CRASHED before `jump` may restart.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `jump`, in, 1: jump request (level).
- `pause`, in, 1: pause request (level).
- `crash`, in, 1: collision detected (level or pulse), from the collision unit.
- `update`, out, 1: one-cycle frame tick.
- `timer`, out, TIMER_W: frame index, 0..FPS-1.
- `state`, out, 2: WAITING=0, RUNNING=1, CRASHED=2, PAUSED=3.
- `started`, out, 1: high from the first start onward.
- `restart`, out, 1: one-cycle pulse on every transition into RUNNING from WAITING or CRASHED.
- `speed`, out, SPEED_W: game speed (pixel speed × 1024).
- `has_obstacles`, out, 1: obstacle generation enable.
- `rng_load`, out, 1: PRNG seed-load enable.

## Operation

- Reset values: state WAITING, `update` 0, `timer` 0, `started` 0, `restart` 0, `speed` 0, `has_obstacles` 0, `rng_load` 1. Internal counters are 0.
- Frame counter:
  - Counts 0..CLK_PER_FRAME-1 and runs in all states.
  - `update` is registered and asserts in the cycle after the counter wraps, so the first tick lands CLK_PER_FRAME cycles after reset deasserts. Ticks then repeat every CLK_PER_FRAME cycles.
  - `timer` increments on the wrap and returns to 0 after FPS-1.
- State transitions and per-state actions are evaluated only in cycles where `update`=1, with one exception: crash in RUNNING.
- WAITING:
  - On `update`&`jump`: go to RUNNING. `speed`←SPEED_INIT, clear counter←0, `has_obstacles`←0, `started`←1, pulse `restart`, `rng_load`←0 (stays 0 until reset).
- RUNNING:
  - Any cycle with `crash`=1: next cycle go to CRASHED. The crash does not wait for `update`. `speed` and `has_obstacles` freeze and the lockout counter clears.
  - Otherwise on `update` with `pause`=1: go to PAUSED. No acceleration that frame.
  - Otherwise on `update`:
    - `speed`←min(speed+ACCEL, MAX_SPEED), computed at SPEED_W+1 bits.
    - Clear counter increments, saturating at CLEAR_FRAMES.
    - `has_obstacles`←1 once the counter reaches CLEAR_FRAMES; it then stays 1 until the next restart.
- PAUSED:
  - All outputs hold; `crash` is ignored.
  - On `update`&!`pause`: go to RUNNING. The first running frame accelerates on the following tick.
- CRASHED:
  - `speed` and `has_obstacles` hold.
  - The lockout counter increments per `update`, saturating at RESTART_FRAMES.
  - On `update`&`jump` with the counter already at RESTART_FRAMES: go to RUNNING with the same initialisation as the WAITING start, and pulse `restart`.
  - `jump` before lockout expiry is ignored; it is not queued.
- Simultaneous events:
  - crash and pause in the same tick: crash wins.
  - crash in the same cycle as the WAITING→RUNNING tick: ignored, because state was not yet RUNNING.
- Reset asserted mid-operation returns everything to the reset values asynchronously, including `rng_load`←1.

## Timing

- `update` width: exactly 1 cycle. Period: exactly CLK_PER_FRAME.
- State, speed, counters and `restart` change in the cycle after the qualifying `update` (1-cycle latency). `restart` is high for that one cycle only.
- Crash latency: 1 cycle from `crash` to `state`=CRASHED, independent of tick phase.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

Parameters for all scenarios: CLK_PER_FRAME=4, FPS=6, SPEED_INIT=6144, MAX_SPEED=6150, ACCEL=4, CLEAR_FRAMES=3, RESTART_FRAMES=2.

- **Reset then idle 30 cycles** → `update` high at cycles 4, 8, 12, …; `timer` sequence 1..5,0,1; state 0; `rng_load`=1.
- **`jump` held from reset** → the first tick moves state to 1 and pulses `restart` once. `speed` reads 6144, then 6148, then 6150, then stays 6150 (saturated). `has_obstacles` rises after the 3rd running tick. `rng_load`=0.
- **`crash` pulsed 1 cycle mid-frame while RUNNING** → state=2 the next cycle and `speed` frozen. With `jump` held, restart occurs only on the 3rd tick after the crash; `speed` returns to 6144 and `has_obstacles` returns to 0.
- **`pause` asserted during RUNNING** → state 3 on the next tick and `speed` constant over 5 ticks. A `crash` pulse during PAUSED has no effect. Release of `pause` → state 1 on the next tick.
- **`crash` and `pause` asserted together on a tick** → state 2, not 3.
- **Reset asserted for 1 cycle mid-RUNNING, between clock edges** → outputs at reset values immediately; `rng_load`=1; `update` next high 4 cycles after release.
